// File: rtl/mips_data_mem_responder.sv
// mips_data_mem_responder
// Memory-side responder for the MIPS core load/store port. It accepts one
// request per valid/ready handshake and answers after WAIT_CYCLES wait
// states with load data, a store acknowledgement or an error flag.
module mips_data_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    // The wait counter is 4 bits wide, so larger settings cannot be honoured.
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("mips_data_mem_responder: WAIT_CYCLES must be within 0..15");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         state;
    logic [3:0]     cnt;
    logic           lat_we;
    logic           lat_err;
    logic [IW-1:0]  lat_idx;
    logic [31:0]    lat_wdata;
    logic [3:0]     lat_be;

    logic [31:0]    mem [DEPTH];

    logic           accept;
    logic           req_bad;
    logic           src_we;
    logic           src_err;
    logic [IW-1:0]  src_idx;
    logic [31:0]    load_word;

    // Request decode, plus the word to be presented when entering RESP.
    // With no wait states RESP is entered on the accept edge itself, so the
    // response is taken from the live request instead of the latched copy.
    always_comb begin
        accept    = req_valid & req_ready & (state == S_IDLE);
        req_bad   = (req_addr[1:0] != 2'b00) || ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
        src_we    = lat_we;
        src_err   = lat_err;
        src_idx   = lat_idx;
        if (state == S_IDLE) begin
            src_we  = req_we;
            src_err = req_bad;
            src_idx = req_addr[IW+1:2];
        end
        load_word = '0;
        if (!src_we && !src_err) begin
            load_word = mem[src_idx];
        end
    end

    // Handshake FSM with registered outputs; reset aborts any transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            lat_we     <= 1'b0;
            lat_err    <= 1'b0;
            lat_idx    <= '0;
            lat_wdata  <= '0;
            lat_be     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        lat_we    <= req_we;
                        lat_err   <= req_bad;
                        lat_idx   <= req_addr[IW+1:2];
                        lat_wdata <= req_wdata;
                        lat_be    <= req_be;
                        if (WAIT_CYCLES > 0) begin
                            state <= S_WAIT;
                            cnt   <= CNT_INIT;
                        end else begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= src_err;
                            resp_rdata <= load_word;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= src_err;
                        resp_rdata <= load_word;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state      <= S_IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Store commit on the edge that ends RESP; only enabled lanes change.
    // Reset forces the FSM out of RESP asynchronously, which cancels the write.
    always_ff @(posedge clk) begin
        if (state == S_RESP && lat_we && !lat_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (lat_be[i]) begin
                    mem[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Directed bench for mips_data_mem_responder: a vector table of complete
// transactions on a WAIT_CYCLES=2 instance, hand-written reset-abort
// sequences, and a WAIT_CYCLES=0 instance driven back-to-back.
module tb_mips_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    logic        req_valid, req_ready, req_we, resp_valid, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [3:0]  req_be;

    logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_err;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
    logic [3:0]  b_req_be;

    mips_data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    mips_data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [15];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait (bounded) for ready, and return just after the accept edge.
    // Inputs are then scrambled so any use of unlatched values shows up.
    task automatic start_req(input string name, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be);
        int n;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        check({name, "_ready"}, 32'(req_ready), 32'd1);
        step();
        req_we    = ~we;
        req_addr  = 32'h0000_0010;
        req_wdata = 32'hFFFF_FFFF;
        req_be    = 4'hF;
    endtask

    // Full transaction: latency counted in edges from the accept edge (inclusive).
    task automatic txn(input string name, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_rdata, input logic exp_err);
        int lat;
        start_req(name, we, addr, wdata, be);
        check({name, "_busy"}, 32'(req_ready), 32'd0);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            step();
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'd3);
        check({name, "_rdata"}, resp_rdata, exp_rdata);
        check({name, "_err"}, 32'(resp_err), 32'(exp_err));
        req_valid = 1'b0;
        step();
        check({name, "_strobe_one_cycle"}, {30'd0, resp_valid, req_ready}, 32'd1);
        check({name, "_rdata_idle"}, resp_rdata, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF,    32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10,  32'h0,        4'h0,    32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h10,  32'h000000AA, 4'b0001, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 32'h10,  32'h0,        4'hF,    32'hDEADBEAA, 1'b0};
        vecs[4]  = '{1'b0, 32'h12,  32'h0,        4'hF,    32'h0,        1'b1};
        vecs[5]  = '{1'b0, 32'h400, 32'h0,        4'hF,    32'h0,        1'b1};
        vecs[6]  = '{1'b0, 32'h10,  32'h0,        4'hF,    32'hDEADBEAA, 1'b0};
        vecs[7]  = '{1'b1, 32'h3FC, 32'hAABBCCDD, 4'hF,    32'h0,        1'b0};
        vecs[8]  = '{1'b1, 32'h3FC, 32'h11223344, 4'b1010, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 32'h3FC, 32'h0,        4'h0,    32'h11BB33DD, 1'b0};
        vecs[10] = '{1'b1, 32'h3FC, 32'hFFFFFFFF, 4'h0,    32'h0,        1'b0};
        vecs[11] = '{1'b0, 32'h3FC, 32'h0,        4'hF,    32'h11BB33DD, 1'b0};
        vecs[12] = '{1'b1, 32'h11,  32'h00000000, 4'hF,    32'h0,        1'b1};
        vecs[13] = '{1'b0, 32'h10,  32'h0,        4'hF,    32'hDEADBEAA, 1'b0};
        vecs[14] = '{1'b1, 32'h20,  32'hCAFEF00D, 4'hF,    32'h0,        1'b0};

        reset       = 1'b1;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_be      = '0;
        b_req_valid = 1'b0;
        b_req_we    = 1'b0;
        b_req_addr  = 32'h0;
        b_req_wdata = '0;
        b_req_be    = 4'hF;

        // Reset held for 100 ns
        #100;
        step();
        check("reset_ready", 32'(req_ready), 32'd0);
        check("reset_outputs", {resp_rdata[30:0], resp_valid}, 32'd0);
        check("reset_err", 32'(resp_err), 32'd0);
        reset = 1'b0;
        #1;
        check("release_ready_before_edge", 32'(req_ready), 32'd0);
        step();
        check("release_ready_after_edge", 32'(req_ready), 32'd1);

        for (int i = 0; i < 15; i++) begin
            txn($sformatf("v%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Reset during WAIT of a store: no response, no write
        start_req("abort_wait", 1'b1, 32'h20, 32'h12345678, 4'hF);
        reset = 1'b1;
        #1;
        check("abort_wait_outputs", {30'd0, resp_valid, req_ready}, 32'd0);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("abort_wait_quiet%0d", i), 32'(resp_valid), 32'd0);
        end
        reset = 1'b0;
        step();
        check("abort_wait_ready", 32'(req_ready), 32'd1);
        txn("abort_wait_readback", 1'b0, 32'h20, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0);

        // Reset during RESP of a store: strobe drops at once, no write
        begin
            int n;
            start_req("abort_resp", 1'b1, 32'h20, 32'h12345678, 4'hF);
            n = 0;
            while (!resp_valid && n < 20) begin
                step();
                n++;
            end
            check("abort_resp_reached", 32'(resp_valid), 32'd1);
            reset = 1'b1;
            #1;
            check("abort_resp_drop", {30'd0, resp_valid, req_ready}, 32'd0);
            req_valid = 1'b0;
            step();
            step();
            reset = 1'b0;
            step();
            check("abort_resp_ready", 32'(req_ready), 32'd1);
        end
        txn("abort_resp_readback", 1'b0, 32'h20, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0);

        // Zero wait states, request held continuously
        check("b_ready_idle", 32'(b_req_ready), 32'd1);
        b_req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic expv;
            step();
            expv = (i % 2 == 0);
            check($sformatf("b_valid%0d", i), 32'(b_resp_valid), 32'(expv));
            check($sformatf("b_ready%0d", i), 32'(b_req_ready), 32'(!expv));
            check($sformatf("b_err%0d", i), 32'(b_resp_err), 32'd0);
        end
        b_req_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
